// File: rtl/clock_pkg.sv
// Shared definitions for the key conditioning front-end: channel FSM encoding
// and the default 50 MHz timing constants.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEF_NUM_KEYS        = 3;
    localparam int DEF_ACTIVE_LOW      = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
    localparam int DEF_HOLD_CYCLES     = 25000000;  // 500 ms at 50 MHz
    localparam int DEF_REPEAT_CYCLES   = 5000000;   // 100 ms at 50 MHz

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the raw board inputs and the conditioned pulse outputs.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    // master is the board / stimulus side, slave is the conditioner
    modport master (output key_raw, input key_level, key_press, key_release);
    modport slave  (input key_raw, output key_level, key_press, key_release);
endinterface

// File: rtl/key_conditioner_key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and press/release pulses.
// Auto-repeat of key_press while held is built only with KEY_AUTOREPEAT_EN.
module key_debounce_ch
    import clock_pkg::*;
#(
    parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;
    localparam logic RELEASED_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    logic             sync_p0;
    logic             sync_p1;
    logic             pressed;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    // stage p0/p1: synchronise the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= RELEASED_LVL;
            sync_p1 <= RELEASED_LVL;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] hold_cnt;
    logic             repeating;
`endif

    // stage p2: debounce FSM with registered level and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            hold_cnt    <= '0;
            repeating   <= 1'b0;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
`ifdef KEY_AUTOREPEAT_EN
            // First repeat after the hold time, then at the shorter repeat period
            if (state == PRESSED && pressed) begin
                if (hold_cnt == (repeating ? REPEAT_LAST : HOLD_LAST)) begin
                    key_press <= 1'b1;
                    hold_cnt  <= '0;
                    repeating <= 1'b1;
                end else begin
                    hold_cnt <= sat_inc(hold_cnt);
                end
            end else begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS raw buttons/switches into clean levels and one-cycle
// press/release pulses. Optional auto-repeat: define KEY_AUTOREPEAT_EN.
module key_conditioner
    import clock_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             original_clk,
    input  logic             clr,
    key_conditioner_if.slave keys
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk         (original_clk),
            .rst         (clr),
            .key_raw     (keys.key_raw[i]),
            .key_level   (keys.key_level[i]),
            .key_press   (keys.key_press[i]),
            .key_release (keys.key_release[i])
        );
    end

endmodule
